multicycle_datapath: RTL and testbench



---
 rtl/multicycle_datapath.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I-subset datapath (add/sub/and/or/slt, addi, lw, sw, beq).
// One shared ALU serves PC increment, branch target, address and arithmetic.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   pc           current program counter (byte address)
//   state        FSM state for debug (FETCH=0 .. HALT=5)
//   retire       one-cycle pulse per completed instruction
//   halted       high while the FSM sits in HALT
//   instr_count  retired-instruction counter (wraps)
module multicycle_datapath #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned IMEM_WORDS = 32,
  parameter int unsigned DMEM_WORDS = 32,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            retire,
  output logic            halted,
  output logic [31:0]     instr_count
);

  localparam int unsigned IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int unsigned RAW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] MEMORY    = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;

  logic [XLEN-1:0] imem [IMEM_WORDS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];
  logic [XLEN-1:0] regs [REG_COUNT];

  logic [XLEN-1:0] ir, a, b, alu_out, mdr, old_pc;

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  // Instruction classification
  logic is_r, is_addi, is_lw, is_sw, is_beq, supported;
  always_comb begin
    is_r = 1'b0;
    if (opcode == 7'b0110011) begin
      if (funct7 == 7'b0000000)
        is_r = (funct3 == 3'b000) || (funct3 == 3'b111) ||
               (funct3 == 3'b110) || (funct3 == 3'b010);
      else if (funct7 == 7'b0100000)
        is_r = (funct3 == 3'b000);
    end
    is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
    is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_beq    = (opcode == 7'b1100011) && (funct3 == 3'b000);
    supported = (ir != '0) && (is_r || is_addi || is_lw || is_sw || is_beq);
  end

  // Immediate generation for I, S and B formats
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm;
  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm   = is_sw ? imm_s : (is_beq ? imm_b : imm_i);

  // Shared ALU: operand selection depends on state and instruction class
  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic [2:0]      alu_op;
  always_comb begin
    alu_a  = a;
    alu_b  = imm;
    alu_op = OP_ADD;
    if (state == FETCH) begin
      alu_a = pc;
      alu_b = XLEN'(4);
    end else if (is_beq) begin
      alu_a = old_pc;
      alu_b = imm_b;
    end else if (is_r) begin
      alu_b = b;
      case (funct3)
        3'b000:  alu_op = (funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
        3'b111:  alu_op = OP_AND;
        3'b110:  alu_op = OP_OR;
        3'b010:  alu_op = OP_SLT;
        default: alu_op = OP_ADD;
      endcase
    end
    case (alu_op)
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
      default: alu_res = alu_a + alu_b;
    endcase
  end

  // Address range/alignment checks
  logic fetch_ok, mem_ok;
  assign fetch_ok = (pc[1:0] == 2'b00) && ((pc >> 2) < XLEN'(IMEM_WORDS));
  assign mem_ok   = (alu_out[1:0] == 2'b00) && ((alu_out >> 2) < XLEN'(DMEM_WORDS));

  // Register file read ports with x0 hardwired to zero
  logic [XLEN-1:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && 32'(rs1) < REG_COUNT) rs1_val = regs[rs1[RAW-1:0]];
    if (rs2 != 5'd0 && 32'(rs2) < REG_COUNT) rs2_val = regs[rs2[RAW-1:0]];
  end

  // Next-state and control decode
  logic [2:0] state_n;
  logic ir_ld, pc_we, ab_ld, alu_ld, mdr_ld, reg_we, dmem_we, retire_n;
  always_comb begin
    state_n  = state;
    ir_ld    = 1'b0;
    pc_we    = 1'b0;
    ab_ld    = 1'b0;
    alu_ld   = 1'b0;
    mdr_ld   = 1'b0;
    reg_we   = 1'b0;
    dmem_we  = 1'b0;
    retire_n = 1'b0;
    case (state)
      FETCH: begin
        if (fetch_ok) begin
          ir_ld   = 1'b1;
          pc_we   = 1'b1;
          state_n = DECODE;
        end else begin
          state_n = HALT;
        end
      end
      DECODE: begin
        if (supported) begin
          ab_ld   = 1'b1;
          state_n = EXECUTE;
        end else begin
          state_n = HALT;
        end
      end
      EXECUTE: begin
        if (is_beq) begin
          pc_we    = (a == b);
          retire_n = 1'b1;
          state_n  = FETCH;
        end else begin
          alu_ld  = 1'b1;
          state_n = (is_lw || is_sw) ? MEMORY : WRITEBACK;
        end
      end
      MEMORY: begin
        if (!mem_ok) begin
          state_n = HALT;
        end else if (is_sw) begin
          dmem_we  = 1'b1;
          retire_n = 1'b1;
          state_n  = FETCH;
        end else begin
          mdr_ld  = 1'b1;
          state_n = WRITEBACK;
        end
      end
      WRITEBACK: begin
        reg_we   = (rd != 5'd0) && (32'(rd) < REG_COUNT);
        retire_n = 1'b1;
        state_n  = FETCH;
      end
      HALT:    state_n = HALT;
      default: state_n = HALT;
    endcase
  end

  // State register and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      retire      <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state  <= state_n;
      retire <= retire_n;
      halted <= (state_n == HALT);
      if (retire_n) instr_count <= instr_count + 32'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= XLEN'(RESET_PC);
      old_pc  <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      if (ir_ld) begin
        ir     <= imem[pc[IAW+1:2]];
        old_pc <= pc;
      end
      if (pc_we)  pc      <= alu_res;
      if (ab_ld) begin
        a <= rs1_val;
        b <= rs2_val;
      end
      if (alu_ld) alu_out <= alu_res;
      if (mdr_ld) mdr     <= dmem[alu_out[DAW+1:2]];
    end
  end

  // Architectural storage writes; suppressed on a reset edge
  always_ff @(posedge clk) begin
    if (!reset && reg_we)  regs[rd[RAW-1:0]]      <= is_lw ? mdr : alu_out;
    if (!reset && dmem_we) dmem[alu_out[DAW+1:2]] <= b;
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath.
module tb_multicycle_datapath;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        retire;
  logic        halted;
  logic [31:0] instr_count;

  int n_pass  = 0;
  int n_total = 0;

  int          cyc;
  int          n_ret;
  int          ret_cyc [8];
  logic [31:0] ret_pc  [8];
  logic [31:0] pc_hold;

  multicycle_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .state       (state),
    .retire      (retire),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
  endfunction

  // Called at a negedge: hold reset and wipe the storage arrays.
  task automatic begin_test();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dut.imem[i] <= 32'h0;
      dut.dmem[i] <= 32'h0;
      dut.regs[i] <= 32'h0;
    end
  endtask

  // Let reset be sampled, then release it at the following negedge.
  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Run until halted or the budget expires, logging retire cycles and pcs.
  task automatic run(input int max_cyc);
    cyc   = 0;
    n_ret = 0;
    while (!halted && cyc < max_cyc) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (retire && n_ret < 8) begin
        ret_cyc[n_ret] = cyc;
        ret_pc[n_ret]  = pc;
        n_ret++;
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);

    // 1: straight-line arithmetic
    begin_test();
    dut.imem[0] <= addi(5'd1, 5'd0, 12'd5);
    dut.imem[1] <= addi(5'd2, 5'd1, 12'hFFD);
    dut.imem[2] <= enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    dut.imem[3] <= enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd4);
    release_reset();
    check("t1_reset_state", 32'(state), 32'd0);
    check("t1_reset_pc", pc, 32'h0);
    run(100);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_x1", dut.regs[1], 32'd5);
    check("t1_x2", dut.regs[2], 32'd2);
    check("t1_x3", dut.regs[3], 32'd7);
    check("t1_x4", dut.regs[4], 32'hFFFF_FFFD);
    check("t1_count", instr_count, 32'd4);
    check("t1_nret", 32'(n_ret), 32'd4);
    check("t1_ret0_cyc", 32'(ret_cyc[0]), 32'd4);
    check("t1_last_ret_cyc", 32'(ret_cyc[3]), 32'd16);
    check("t1_halt_cyc", 32'(cyc), 32'd18);
    check("t1_halt_state", 32'(state), 32'd5);
    check("t1_halt_pc", pc, 32'h14);

    // 2: load/store round trip
    begin_test();
    dut.dmem[3] <= 32'h1234_5678;
    dut.imem[0] <= lw(5'd5, 5'd0, 12'd12);
    dut.imem[1] <= enc_s(12'd16, 5'd5, 5'd0);
    dut.imem[2] <= lw(5'd6, 5'd0, 12'd16);
    release_reset();
    run(100);
    check("t2_x5", dut.regs[5], 32'h1234_5678);
    check("t2_x6", dut.regs[6], 32'h1234_5678);
    check("t2_dmem4", dut.dmem[4], 32'h1234_5678);
    check("t2_lw_first", 32'(ret_cyc[0]), 32'd5);
    check("t2_sw_gap", 32'(ret_cyc[1] - ret_cyc[0]), 32'd4);
    check("t2_lw_gap", 32'(ret_cyc[2] - ret_cyc[1]), 32'd5);
    check("t2_count", instr_count, 32'd3);

    // 3: beq taken, then not taken
    begin_test();
    dut.regs[1] <= 32'd7;
    dut.regs[2] <= 32'd7;
    dut.imem[0] <= enc_b(13'd8, 5'd2, 5'd1);
    dut.imem[1] <= addi(5'd11, 5'd0, 12'd1);
    dut.imem[2] <= addi(5'd1, 5'd0, 12'd8);
    dut.imem[3] <= addi(5'd10, 5'd0, 12'd1);
    dut.imem[4] <= enc_b(13'd8, 5'd2, 5'd1);
    release_reset();
    run(100);
    check("t3_taken_cyc", 32'(ret_cyc[0]), 32'd3);
    check("t3_taken_pc", ret_pc[0], 32'h08);
    check("t3_skipped_x11", dut.regs[11], 32'd0);
    check("t3_x10", dut.regs[10], 32'd1);
    check("t3_nt_cyc", 32'(ret_cyc[3]), 32'd14);
    check("t3_nt_pc", ret_pc[3], 32'h14);

    // 4: x0 protection and signed slt
    begin_test();
    dut.regs[8]  <= 32'hFFFF_FFFF;
    dut.regs[9]  <= 32'd1;
    dut.regs[12] <= 32'h55;
    dut.regs[13] <= 32'h55;
    dut.imem[0] <= addi(5'd0, 5'd0, 12'd9);
    dut.imem[1] <= enc_r(7'b0000000, 5'd9, 5'd8, 3'b010, 5'd7);
    dut.imem[2] <= enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd12);
    dut.imem[3] <= enc_r(7'b0000000, 5'd8, 5'd9, 3'b010, 5'd13);
    release_reset();
    run(100);
    check("t4_x0", dut.regs[0], 32'd0);
    check("t4_x7_slt", dut.regs[7], 32'd1);
    check("t4_x12_x0read", dut.regs[12], 32'd0);
    check("t4_x13_slt", dut.regs[13], 32'd0);

    // 5a: misaligned load halts from MEMORY
    begin_test();
    dut.regs[1] <= 32'hAA;
    dut.imem[0] <= lw(5'd1, 5'd0, 12'd2);
    release_reset();
    run(50);
    check("t5a_halted", 32'(halted), 32'd1);
    check("t5a_halt_cyc", 32'(cyc), 32'd4);
    check("t5a_nret", 32'(n_ret), 32'd0);
    check("t5a_x1", dut.regs[1], 32'hAA);
    pc_hold = pc;
    step(5);
    check("t5a_sticky", 32'(halted), 32'd1);
    check("t5a_pc_frozen", pc, pc_hold);
    check("t5a_retire", 32'(retire), 32'd0);
    check("t5a_count", instr_count, 32'd0);

    // 5b: store past the end of dmem halts with no write
    begin_test();
    dut.regs[5] <= 32'h99;
    dut.dmem[0] <= 32'h1111;
    dut.imem[0] <= enc_s(12'd128, 5'd5, 5'd0);
    release_reset();
    run(50);
    check("t5b_halted", 32'(halted), 32'd1);
    check("t5b_halt_cyc", 32'(cyc), 32'd4);
    check("t5b_dmem0", dut.dmem[0], 32'h1111);
    check("t5b_count", instr_count, 32'd0);

    // 6: reset during WRITEBACK of add
    begin_test();
    dut.regs[1] <= 32'd3;
    dut.regs[2] <= 32'd4;
    dut.regs[3] <= 32'h77;
    dut.imem[0] <= addi(5'd5, 5'd0, 12'd1);
    dut.imem[1] <= enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    release_reset();
    step(7);
    check("t6_pre_state", 32'(state), 32'd4);
    check("t6_pre_count", instr_count, 32'd1);
    reset = 1'b1;
    step(1);
    check("t6_x3", dut.regs[3], 32'h77);
    check("t6_pc", pc, 32'h0);
    check("t6_state", 32'(state), 32'd0);
    check("t6_count", instr_count, 32'd0);
    check("t6_retire", 32'(retire), 32'd0);
    check("t6_halted", 32'(halted), 32'd0);
    check("t6_ir", dut.ir, 32'h0);
    check("t6_a", dut.a, 32'h0);
    check("t6_b", dut.b, 32'h0);
    check("t6_aluout", dut.alu_out, 32'h0);
    check("t6_mdr", dut.mdr, 32'h0);
    reset = 1'b0;
    step(1);
    check("t6_next_state", 32'(state), 32'd1);
    check("t6_next_pc", pc, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
